// File: rtl/tick_ctrl_pkg.sv
// Shared definitions for the countdown-timer control stage: press FSM encoding,
// default timing constants and a width helper.
package tick_ctrl_pkg;

   typedef enum logic [1:0] {
      UP   = 2'd0,
      DOWN = 2'd1,
      LONG = 2'd2
   } press_t;

   localparam int CLK_HZ  = 50000000;
   localparam int DB_MS   = 20;
   localparam int LONG_MS = 2000;

   // Number of bits needed to hold values 0..v-1, never less than 1.
   function automatic int clog2(input longint v);
      int r;
      r = 0;
      while ((longint'(1) << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/tick_ctrl_if.sv
// Key input and timer-control outputs of tick_ctrl. The master side is the
// control stage itself; the slave side is the countdown stage / board pin.
interface tick_ctrl_if;
   logic key_n;
   logic key_db;
   logic running;
   logic tick;
   logic clr_req;

   modport master (
      input  key_n,
      output key_db,
      output running,
      output tick,
      output clr_req
   );

   modport slave (
      output key_n,
      input  key_db,
      input  running,
      input  tick,
      input  clr_req
   );
endinterface

// File: rtl/tick_ctrl_key_debounce.sv
// Two-flop synchronizer plus stability counter for the active-low pushbutton.
// key_db follows key_n once the synchronized level has held for DB_CYC cycles.
module key_debounce
   import tick_ctrl_pkg::*;
#(
   parameter int DB_CYC = CLK_HZ / 1000 * DB_MS
) (
   input  logic CLK,
   input  logic CLR,
   input  logic key_n,
   output logic key_db
);

   localparam int             DW   = clog2(DB_CYC);
   localparam logic [DW-1:0]  DMAX = DW'(DB_CYC - 1);

   logic [1:0]    sync;
   logic          key_s;
   logic [DW-1:0] db_cnt;

   assign key_s = sync[1];

   always_ff @(posedge CLK) begin
      if (CLR) begin
         sync   <= 2'b11;
         key_db <= 1'b1;
         db_cnt <= '0;
      end else begin
         sync <= {sync[0], key_n};
         // Any return to the accepted level restarts the stability window.
         if (key_s == key_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DMAX) begin
            key_db <= key_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/tick_ctrl.sv
// Upstream control for the 2-digit countdown timer: debounced key, short-press
// run/pause toggle, long-press clear, and the once-per-DIV-cycles tick enable.
module tick_ctrl
   import tick_ctrl_pkg::*;
#(
   parameter int DIV      = CLK_HZ,
   parameter int DB_CYC   = CLK_HZ / 1000 * DB_MS,
   parameter int LONG_CYC = CLK_HZ / 1000 * LONG_MS
) (
   input  logic        CLK,
   input  logic        CLR,
   tick_ctrl_if.master bus
);

   localparam int            PW   = clog2(DIV);
   localparam int            HW   = clog2(LONG_CYC);
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [HW-1:0] HMAX = HW'(LONG_CYC - 1);

   logic          key_db;
   logic          key_db_q;
   logic          key_fall;
   logic          key_rise;
   press_t        state, state_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic          running, run_nxt;
   logic          clr_evt;
   logic          tick;
   logic          clr_req;
   logic [PW-1:0] pcnt;

   key_debounce #(.DB_CYC(DB_CYC)) u_db (
      .CLK    (CLK),
      .CLR    (CLR),
      .key_n  (bus.key_n),
      .key_db (key_db)
   );

   assign key_fall    = key_db_q & ~key_db;
   assign key_rise    = ~key_db_q & key_db;
   assign bus.key_db  = key_db;
   assign bus.running = running;
   assign bus.tick    = tick;
   assign bus.clr_req = clr_req;

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      run_nxt   = running;
      clr_evt   = 1'b0;
      unique case (state)
         UP: begin
            if (key_fall) begin
               state_nxt = DOWN;
               hold_nxt  = '0;
            end
         end
         DOWN: begin
            // The long-press threshold takes priority over a same-cycle release.
            if (hold_cnt == HMAX) begin
               state_nxt = LONG;
               clr_evt   = 1'b1;
               run_nxt   = 1'b0;
            end else if (key_rise) begin
               state_nxt = UP;
               run_nxt   = ~running;
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         LONG: begin
            if (key_rise) state_nxt = UP;
         end
         default: state_nxt = UP;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state    <= UP;
         key_db_q <= 1'b1;
         hold_cnt <= '0;
         running  <= 1'b0;
         clr_req  <= 1'b0;
         tick     <= 1'b0;
         pcnt     <= '0;
      end else begin
         state    <= state_nxt;
         key_db_q <= key_db;
         hold_cnt <= hold_nxt;
         running  <= run_nxt;
         clr_req  <= clr_evt;
         tick     <= 1'b0;
         // Clear beats a coincident wrap; a pause does not, since running was still 1.
         if (clr_evt) begin
            pcnt <= '0;
         end else if (running) begin
            if (pcnt == PMAX) begin
               pcnt <= '0;
               tick <= 1'b1;
            end else begin
               pcnt <= pcnt + PW'(1);
            end
         end
      end
   end

endmodule
